// File: rtl/wb_mailbox_fifo.sv
// Wishbone classic mailbox: 32-bit word FIFO, 16-bit user IO register, data-pending irq.
// Optional macro WB_MAILBOX_TSTAMP_EN adds a cycle counter (0x10) and last-push stamp (0x14).
//
// Ports:
//   wb_clk_i, wb_rst_i           clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i         Wishbone classic request qualifiers
//   wbs_sel_i[3:0]               byte selects
//   wbs_adr_i[31:0]              byte address, window BASE_ADDR[31:5]
//   wbs_dat_i[31:0]              write data
//   wbs_ack_o, wbs_dat_o[31:0]   single-cycle ack with read data, dat 0 when idle
//   io_out[15:0], io_oeb[15:0]   user IO value, output enables (always driven)
//   irq_o                        registered irq_en & FIFO-not-empty
module wb_mailbox_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] IO_RESET  = 16'h0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb,
    output logic        irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_hit;
    logic [31:0]   r_rdata;
    logic [31:0]   w_rdata;
    logic [31:0]   w_status;
    logic [31:0]   w_wmask;
    logic [2:0]    w_off;
    logic          w_match;
    logic          w_wr;
    logic          w_rd;
    logic          w_full;
    logic          w_empty;
    logic          w_do_push;
    logic          w_do_pop;
    logic          w_flush;
    logic          w_ovf_set;
    logic          w_unf_set;
    logic          w_st_w1c;
    logic          w_unused;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;
    logic          r_irq_en;
    logic [15:0]   r_io;
    logic          r_irq;

`ifdef WB_MAILBOX_TSTAMP_EN
    logic [31:0]   r_tstamp;
    logic [31:0]   r_last_push;
`endif

    // Byte address bits [1:0] carry no information for word registers.
    assign w_unused = ^wbs_adr_i[1:0];

    assign w_match = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_off   = wbs_adr_i[4:2];
    assign w_wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    assign w_wr      = w_hit & wbs_we_i;
    assign w_rd      = w_hit & ~wbs_we_i;
    assign w_do_push = w_wr & (w_off == 3'd0) & ~w_full;
    assign w_do_pop  = w_rd & (w_off == 3'd0) & ~w_empty;
    assign w_ovf_set = w_wr & (w_off == 3'd0) & w_full;
    assign w_unf_set = w_rd & (w_off == 3'd0) & w_empty;
    assign w_flush   = w_wr & (w_off == 3'd3) & wbs_sel_i[0] & wbs_dat_i[1];
    assign w_st_w1c  = w_wr & (w_off == 3'd1) & wbs_sel_i[1];

    assign io_out = r_io;
    assign io_oeb = 16'h0000;
    assign irq_o  = r_irq;

    always_comb begin
        w_state_nxt = r_state;
        w_hit       = 1'b0;
        wbs_ack_o   = 1'b0;
        wbs_dat_o   = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i && w_match) begin
                    w_hit       = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                wbs_ack_o   = 1'b1;
                wbs_dat_o   = r_rdata;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_status           = 32'h0;
        w_status[CW-1:0]   = r_count;
        w_status[8]        = w_empty;
        w_status[9]        = w_full;
        w_status[10]       = r_ovf;
        w_status[11]       = r_unf;
    end

    // Read data is sampled on the accepting edge, before that edge's side effects.
    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            3'd0: w_rdata = w_empty ? 32'h0 : r_mem[r_rptr];
            3'd1: w_rdata = w_status;
            3'd2: w_rdata = {16'h0, r_io};
            3'd3: w_rdata = {31'h0, r_irq_en};
`ifdef WB_MAILBOX_TSTAMP_EN
            3'd4: w_rdata = r_tstamp;
            3'd5: w_rdata = r_last_push;
`endif
            default: w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_rdata  <= 32'h0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_io     <= IO_RESET;
            r_irq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= r_irq_en & (r_count != '0);
            if (w_hit) begin
                r_rdata <= w_rdata;
            end
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else if (w_do_push) begin
                r_wptr  <= r_wptr + AW'(1);
                r_count <= r_count + CW'(1);
            end else if (w_do_pop) begin
                r_rptr  <= r_rptr + AW'(1);
                r_count <= r_count - CW'(1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_st_w1c && wbs_dat_i[10]) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (w_st_w1c && wbs_dat_i[11]) begin
                r_unf <= 1'b0;
            end
            if (w_wr && (w_off == 3'd3) && wbs_sel_i[0]) begin
                r_irq_en <= wbs_dat_i[0];
            end
            if (w_wr && (w_off == 3'd2)) begin
                if (wbs_sel_i[0]) r_io[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) r_io[15:8] <= wbs_dat_i[15:8];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && w_do_push) begin
            r_mem[r_wptr] <= wbs_dat_i & w_wmask;
        end
    end

`ifdef WB_MAILBOX_TSTAMP_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tstamp    <= 32'h0;
            r_last_push <= 32'h0;
        end else begin
            r_tstamp <= r_tstamp + 32'd1;
            if (w_do_push) begin
                r_last_push <= r_tstamp;
            end
        end
    end
`endif

endmodule
